transition_run_encoder: RTL and testbench

- Downstream consumer of the serial transition-detector FSM (its 1-cycle "input changed" pulse) and of the raw serial bit stream.
- Converts the stream into run-length records {level, length}, one per closed run.
- Records are buffered in a small FIFO and drained over a valid/ready interface.
- Sits between the transition detector and the packetiser / debug readout.

---
 rtl/run_enc_pkg.sv | 28 ++
 rtl/run_rec_fifo.sv | 56 +++++
 rtl/transition_run_encoder.sv | 100 ++++++++++
 tb/tb_transition_run_encoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/run_enc_pkg.sv
// Shared sizing defaults, record layout and state encoding
// for the transition run encoder.
package run_enc_pkg;

  localparam int LEN_W_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int REC_W_DEF = 1 + LEN_W_DEF;

  typedef struct packed {
    logic                 level;
    logic [LEN_W_DEF-1:0] len;
  } run_rec_t;

  typedef enum logic [1:0] {
    ST_PRIME,
    ST_START,
    ST_RUN
  } run_state_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int rec_w(input int len_w);
    return 1 + len_w;
  endfunction

endpackage

// File: rtl/run_rec_fifo.sv
// Synchronous first-word-fall-through record FIFO;
// the head entry is visible on pop_data whenever it is non-empty.
module run_rec_fifo
  import run_enc_pkg::*;
#(
  parameter int W     = REC_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [W-1:0]            push_data,
  input  logic                    pop,
  output logic [W-1:0]            pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign do_push = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push)
                     - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/transition_run_encoder.sv
// Turns a serial bit stream plus change pulses into
// {level, length} run records drained over valid/ready.
module transition_run_encoder
  import run_enc_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bit_in,
  input  logic                    chg_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_level,
  output logic [LEN_W-1:0]        out_len,
  output logic [cnt_w(DEPTH)-1:0] fifo_count,
  output logic                    overflow
);

  localparam int RW = rec_w(LEN_W);
  localparam logic [LEN_W-1:0] MAX = '1;

  run_state_e       state;
  run_state_e       state_n;
  logic             bit_d;
  logic             run_level;
  logic             run_level_n;
  logic [LEN_W-1:0] run_cnt;
  logic [LEN_W-1:0] run_cnt_n;
  logic             push;
  logic             full;
  logic             empty;
  logic [RW-1:0]    head;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_PRIME;
      bit_d     <= 1'b0;
      run_level <= 1'b0;
      run_cnt   <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      bit_d     <= bit_in;
      run_level <= run_level_n;
      run_cnt   <= run_cnt_n;
      if (push & full & ~out_ready)
        overflow <= 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    run_level_n = run_level;
    run_cnt_n   = run_cnt;
    push        = 1'b0;
    unique case (state)
      ST_PRIME: state_n = ST_START;
      // the detector has no history for this sample, so chg_in is ignored
      ST_START: begin
        run_level_n = bit_d;
        run_cnt_n   = LEN_W'(1);
        state_n     = ST_RUN;
      end
      ST_RUN: begin
        if (chg_in) begin
          push        = 1'b1;
          run_level_n = bit_d;
          run_cnt_n   = LEN_W'(1);
        end else if (run_cnt == MAX) begin
          push      = 1'b1;
          run_cnt_n = LEN_W'(1);
        end else begin
          run_cnt_n = run_cnt + LEN_W'(1);
        end
      end
      default: state_n = ST_PRIME;
    endcase
  end

  run_rec_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({run_level, run_cnt}),
    .pop       (out_ready),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign out_valid            = ~empty;
  assign {out_level, out_len} = head;

endmodule

// File: tb/tb_transition_run_encoder.sv
// Directed bench for transition_run_encoder: a run-list model
// checked every cycle plus hand-computed record expectations.
module tb_transition_run_encoder;
  import run_enc_pkg::*;

  localparam int MAXLEN = (1 << LEN_W_DEF) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_in;
  logic       chg;
  logic       out_valid;
  logic       out_ready;
  logic       out_level;
  logic [7:0] out_len;
  logic [2:0] fifo_count;
  logic       overflow;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  transition_run_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .chg_in     (chg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_level  (out_level),
    .out_len    (out_len),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  // registered transition detector feeding chg_in
  logic det_last;
  logic det_first;
  always @(posedge clk) begin
    if (reset) begin
      chg       <= 1'b0;
      det_first <= 1'b1;
      det_last  <= 1'b0;
    end else begin
      chg       <= det_first ? 1'b0 : (bit_in != det_last);
      det_last  <= bit_in;
      det_first <= 1'b0;
    end
  end

  // model: sample list -> closed runs -> bounded queue
  run_rec_t mq[$];
  run_rec_t log_q[$];
  bit       m_ovf;
  bit       m_primed;
  bit       prev_bit;
  bit       cur_lvl;
  int       cur_len;

  always @(posedge clk) begin
    bit       emit;
    bit       s;
    bit       pop;
    run_rec_t r;
    emit = 1'b0;
    r    = '0;
    if (reset) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_primed = 1'b0;
      cur_len  = 0;
    end else begin
      if (m_primed) begin
        s = prev_bit;
        if (cur_len == 0) begin
          cur_lvl = s;
          cur_len = 1;
        end else if (s != cur_lvl || cur_len == MAXLEN) begin
          emit    = 1'b1;
          r.level = cur_lvl;
          r.len   = 8'(cur_len);
          cur_lvl = s;
          cur_len = 1;
        end else begin
          cur_len++;
        end
      end
      m_primed = 1'b1;
      pop = (mq.size() > 0) && out_ready;
      if (pop)
        void'(mq.pop_front());
      if (emit) begin
        if (mq.size() < DEPTH_DEF)
          mq.push_back(r);
        else
          m_ovf = 1'b1;
      end
    end
    prev_bit = bit_in;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    run_rec_t h;
    if (chk_en && !reset) begin
      check("valid", int'(out_valid), int'(mq.size() > 0));
      check("count", int'(fifo_count), mq.size());
      check("overflow", int'(overflow), int'(m_ovf));
      if (mq.size() > 0) begin
        check("level", int'(out_level), int'(mq[0].level));
        check("len", int'(out_len), int'(mq[0].len));
      end
      if (out_valid && out_ready) begin
        h.level = out_level;
        h.len   = out_len;
        log_q.push_back(h);
      end
    end
  end

  function automatic int lg(input int i);
    if (i < log_q.size())
      return int'(log_q[i]);
    return -1;
  endfunction

  task automatic step(input logic b, input logic r);
    bit_in    = b;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bit_in    = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    log_q.delete();
  endtask

  initial begin
    reset     = 1'b1;
    bit_in    = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    do_reset();
    chk_en = 1'b1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_level", int'(out_level), 0);
    check("rst_len", int'(out_len), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_ovf", int'(overflow), 0);

    // 1: 0,0,0,1,1,0,0 -> (0,3) (1,2)
    begin
      bit v [10] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
      foreach (v[i]) step(v[i], 1'b1);
    end
    check("t1_n", log_q.size(), 2);
    check("t1_r0", lg(0), 3);
    check("t1_r1", lg(1), 256 + 2);
    check("t1_ovf", int'(overflow), 0);
    check("t1_count", int'(fifo_count), 0);

    // 2: 300 zeros saturate into (0,255) (0,45)
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    check("t2_n", log_q.size(), 2);
    check("t2_r0", lg(0), 255);
    check("t2_r1", lg(1), 45);

    // 3: alternating with no consumer overflows
    do_reset();
    for (int i = 0; i < 10; i++) step(1'(i % 2), 1'b0);
    check("t3_count", int'(fifo_count), 4);
    check("t3_ovf", int'(overflow), 1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    check("t3_r0", lg(0), 1);
    check("t3_r1", lg(1), 257);
    check("t3_r2", lg(2), 1);
    check("t3_r3", lg(3), 257);
    check("t3_ovf_hold", int'(overflow), 1);
    check("t3_drained", int'(fifo_count), 0);

    // 4: push and pop on a full FIFO
    do_reset();
    for (int i = 0; i < 6; i++) step(1'(i % 2), 1'b0);
    check("t4_full", int'(fifo_count), 4);
    check("t4_head0", int'(out_level), 0);
    step(1'b1, 1'b1);
    check("t4_count", int'(fifo_count), 4);
    check("t4_ovf", int'(overflow), 0);
    check("t4_head_lvl", int'(out_level), 1);
    check("t4_head_len", int'(out_len), 1);
    check("t4_popped", lg(0), 1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);

    // 5: reset mid-run discards FIFO and partial run
    do_reset();
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("t5_pre", int'(fifo_count), 1);
    do_reset();
    check("t5_valid", int'(out_valid), 0);
    check("t5_count", int'(fifo_count), 0);
    begin
      bit v [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
      foreach (v[i]) step(v[i], 1'b1);
    end
    check("t5_n", log_q.size(), 1);
    check("t5_r0", lg(0), 3);

    // 6: head held stable under backpressure
    do_reset();
    begin
      bit v [4] = '{0, 0, 1, 1};
      foreach (v[i]) step(v[i], 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      check("t6_valid", int'(out_valid), 1);
      check("t6_level", int'(out_level), 0);
      check("t6_len", int'(out_len), 2);
    end
    check("t6_nopop", log_q.size(), 0);
    step(1'b1, 1'b1);
    check("t6_count", int'(fifo_count), 0);
    check("t6_r0", lg(0), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
